chave_debounce: RTL and testbench

Input conditioning stage for the 4-bit `Chave` switch bank, sitting directly upstream of the 7-segment display multiplexer. Synchronises the raw switches into the `clock` domain, rejects bounce with a per-bank stability counter, and presents a stable switch code together with a decoded digit value. The multiplexer consumes `chave_estavel` and `digito_bcd` instead of raw pins, so contact bounce never reaches `Display`.

---
 rtl/chave_pkg.sv | 43 ++++
 rtl/chave_debounce_sync_2ff.sv | 28 ++
 rtl/chave_debounce.sv | 119 +++++++++++
 tb/tb_chave_debounce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/chave_pkg.sv
// Shared types and constants for the Chave switch-bank conditioning path.
// State encoding for the debounce FSM and the recognised switch codes with
// the digit each one selects on the display multiplexer.
package chave_pkg;

    typedef enum logic [0:0] {
        ESTAVEL  = 1'b0,
        CONTANDO = 1'b1
    } chave_estado_t;

    localparam logic [3:0] CHAVE_COD_3 = 4'b0100;
    localparam logic [3:0] CHAVE_COD_4 = 4'b1100;
    localparam logic [3:0] CHAVE_DIG_3 = 4'd3;
    localparam logic [3:0] CHAVE_DIG_4 = 4'd4;

    typedef struct packed {
        logic [3:0] digito;
        logic       valido;
    } chave_dec_t;

    // Maps a stable switch code to its display digit; unknown codes give 0/invalid.
    function automatic chave_dec_t chave_decode(input logic [3:0] cod);
        chave_dec_t dec;
        dec.digito = 4'd0;
        dec.valido = 1'b0;
        case (cod)
            CHAVE_COD_3: begin
                dec.digito = CHAVE_DIG_3;
                dec.valido = 1'b1;
            end
            CHAVE_COD_4: begin
                dec.digito = CHAVE_DIG_4;
                dec.valido = 1'b1;
            end
            default: begin
                dec.digito = 4'd0;
                dec.valido = 1'b0;
            end
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/chave_debounce_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous level inputs.
// Width is a parameter so other raw inputs can share this block later.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back captures to let metastability settle before use.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/chave_debounce.sv
// chave_debounce: synchronises the 4-bit Chave switch bank, rejects contact
// bounce with a stability counter and presents a committed code plus its
// decoded digit to the display multiplexer.
// Optional feature macro: CHAVE_MUDOU_PULSE_EN enables the one-cycle `mudou`
// change pulse; without it `mudou` is tied low and has no register.
//
// state    | meaning
// ESTAVEL  | sampled code equals committed code, nothing pending
// CONTANDO | a different code is being timed for DEBOUNCE_CYCLES edges
module chave_debounce
    import chave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] Chave,
    output logic [3:0] chave_estavel,
    output logic [3:0] digito_bcd,
    output logic       valido,
    output logic       mudou
);

    // Last count value before commit; the counter is cleared on commit so it never wraps.
    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       w_amostra;
    chave_dec_t       w_dec;

    chave_estado_t    r_estado;
    logic [3:0]       r_candidato;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_estavel;
    logic [3:0]       r_digito;
    logic             r_valido;

    sync_2ff #(
        .W(4)
    ) u_sync (
        .i_clock  (clock),
        .i_reset_n(reset_n),
        .i_d      (Chave),
        .o_q      (w_amostra)
    );

    // Decode the candidate so the digit lands in the same edge as the code.
    assign w_dec = chave_decode(r_candidato);

    // Debounce FSM with counter and registered decode outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= ESTAVEL;
            r_candidato <= '0;
            r_cnt       <= '0;
            r_estavel   <= '0;
            r_digito    <= '0;
            r_valido    <= 1'b0;
        end else begin
            case (r_estado)
                ESTAVEL: begin
                    if (w_amostra != r_estavel) begin
                        r_candidato <= w_amostra;
                        r_cnt       <= '0;
                        r_estado    <= CONTANDO;
                    end
                end
                CONTANDO: begin
                    if (w_amostra == r_estavel) begin
                        r_estado <= ESTAVEL;
                        r_cnt    <= '0;
                    end else if (w_amostra != r_candidato) begin
                        r_candidato <= w_amostra;
                        r_cnt       <= '0;
                    end else if (r_cnt == CNT_FIM) begin
                        r_estavel <= r_candidato;
                        r_digito  <= w_dec.digito;
                        r_valido  <= w_dec.valido;
                        r_estado  <= ESTAVEL;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_estado <= ESTAVEL;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign chave_estavel = r_estavel;
    assign digito_bcd    = r_digito;
    assign valido        = r_valido;

`ifdef CHAVE_MUDOU_PULSE_EN
    logic w_commit;
    logic r_mudou;

    // Same condition that moves the candidate into the committed code.
    assign w_commit = (r_estado == CONTANDO) && (w_amostra != r_estavel) &&
                      (w_amostra == r_candidato) && (r_cnt == CNT_FIM);

    // One-cycle pulse aligned with the new committed code.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mudou <= 1'b0;
        end else begin
            r_mudou <= w_commit;
        end
    end

    assign mudou = r_mudou;
`else
    assign mudou = 1'b0;
`endif

endmodule

// File: tb/tb_chave_debounce.sv
// Bench for chave_debounce with DEBOUNCE_CYCLES = 8: directed corner-case
// sequences, a vector table and randomized stimulus, all checked against a
// run-length reference model of the debounce rule.
module tb_chave_debounce;

    localparam int N = 8;
`ifdef CHAVE_MUDOU_PULSE_EN
    localparam bit MUDOU_EN = 1'b1;
`else
    localparam bit MUDOU_EN = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic [3:0] Chave   = 4'b0000;
    logic [3:0] chave_estavel;
    logic [3:0] digito_bcd;
    logic       valido;
    logic       mudou;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    chave_debounce #(
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .Chave        (Chave),
        .chave_estavel(chave_estavel),
        .digito_bcd   (digito_bcd),
        .valido       (valido),
        .mudou        (mudou)
    );

    task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
        end
    endtask

    // Spec decode table: {valido, digito}
    function automatic logic [4:0] ref_dec(input logic [3:0] c);
        if (c == 4'b0100) return {1'b1, 4'd3};
        if (c == 4'b1100) return {1'b1, 4'd4};
        return 5'd0;
    endfunction

    // Reference model: a code commits once the synchronised sample has shown the
    // same non-stable value on N+1 consecutive evaluated edges.
    logic [3:0] h1 = 4'd0, h2 = 4'd0, m_a = 4'd0, m_est = 4'd0, m_cand = 4'd0;
    int         m_run = 0;
    bit         m_mud = 1'b0;
    logic [4:0] m_dec;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h1 = 0; h2 = 0; m_est = 0; m_cand = 0; m_run = 0; m_mud = 0;
        end else begin
            m_a = h2;
            h2  = h1;
            h1  = Chave;
            m_mud = 1'b0;
            if (m_a == m_est) begin
                m_run = 0;
            end else if (m_run != 0 && m_a == m_cand) begin
                m_run++;
            end else begin
                m_cand = m_a;
                m_run  = 1;
            end
            if (m_run == N + 1) begin
                m_est = m_cand;
                m_mud = 1'b1;
                m_run = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            m_dec = ref_dec(m_est);
            chk("model estavel", chave_estavel, m_est);
            chk("model digito", digito_bcd, m_dec[3:0]);
            chk("model valido", valido, m_dec[4]);
            chk("model mudou", mudou, m_mud & MUDOU_EN);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called just after the edge on which Chave was changed (edge 0).
    task automatic expect_commit(input string nome, input logic [3:0] old_c,
                                 input logic [3:0] nov, input logic [3:0] dig, input logic val);
        repeat (N + 2) tick();
        chk({nome, " pre estavel"}, chave_estavel, old_c);
        chk({nome, " pre mudou"}, mudou, 1'b0);
        tick();
        chk({nome, " estavel"}, chave_estavel, nov);
        chk({nome, " digito"}, digito_bcd, dig);
        chk({nome, " valido"}, valido, val);
        chk({nome, " mudou"}, mudou, MUDOU_EN);
        tick();
        chk({nome, " mudou off"}, mudou, 1'b0);
        chk({nome, " hold"}, chave_estavel, nov);
    endtask

    typedef struct {
        logic [3:0] chave;
        int         hold;
        logic [3:0] est;
        logic [3:0] dig;
        logic       val;
    } vec_t;

    vec_t tab[9];
    int   n_mud;

    initial begin
        tab[0] = '{4'b1100, 12, 4'b1100, 4'd4, 1'b1};
        tab[1] = '{4'b0000,  5, 4'b1100, 4'd4, 1'b1};
        tab[2] = '{4'b0000,  8, 4'b0000, 4'd0, 1'b0};
        tab[3] = '{4'b1010, 12, 4'b1010, 4'd0, 1'b0};
        tab[4] = '{4'b0100,  4, 4'b1010, 4'd0, 1'b0};
        tab[5] = '{4'b1100, 12, 4'b1100, 4'd4, 1'b1};
        tab[6] = '{4'b0110, 12, 4'b0110, 4'd0, 1'b0};
        tab[7] = '{4'b1100, 11, 4'b1100, 4'd4, 1'b1};
        tab[8] = '{4'b0100, 10, 4'b1100, 4'd4, 1'b1};

        // Reset held with Chave = 1100
        Chave = 4'b1100;
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (5) begin
            tick();
            chk("rst estavel", chave_estavel, 4'b0000);
            chk("rst digito", digito_bcd, 4'd0);
            chk("rst valido", valido, 1'b0);
            chk("rst mudou", mudou, 1'b0);
        end
        reset_n = 1'b1;
        expect_commit("rst_rel", 4'b0000, 4'b1100, 4'd4, 1'b1);

        // Clean change 1100 -> 0100
        Chave = 4'b0100;
        expect_commit("clean", 4'b1100, 4'b0100, 4'd3, 1'b1);

        // Glitch to 0000 for 5 cycles
        Chave = 4'b0000;
        repeat (5) tick();
        Chave = 4'b0100;
        n_mud = 0;
        repeat (15) begin
            tick();
            if (mudou) n_mud++;
            chk("glitch estavel", chave_estavel, 4'b0100);
        end
        chk("glitch mudou count", n_mud, 0);

        // Invalid code, also proves the FSM is idle again with a clean count
        Chave = 4'b1010;
        expect_commit("invalid", 4'b0100, 4'b1010, 4'd0, 1'b0);

        // Bounce 0100/1100 every 3 cycles, settle at 0100
        n_mud = 0;
        for (int i = 0; i < 40; i++) begin
            Chave = (((i / 3) % 2) == 0) ? 4'b0100 : 4'b1100;
            tick();
            if (mudou) n_mud++;
            chk("bounce estavel", chave_estavel, 4'b1010);
        end
        chk("bounce mudou count", n_mud, 0);
        Chave = 4'b0100;
        expect_commit("settle", 4'b1010, 4'b0100, 4'd3, 1'b1);

        // Reset mid-count
        Chave = 4'b1100;
        expect_commit("pre_rst", 4'b0100, 4'b1100, 4'd4, 1'b1);
        Chave = 4'b0100;
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async rst estavel", chave_estavel, 4'b0000);
        chk("async rst digito", digito_bcd, 4'd0);
        chk("async rst valido", valido, 1'b0);
        chk("async rst mudou", mudou, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        expect_commit("rst_mid", 4'b0000, 4'b0100, 4'd3, 1'b1);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            Chave = tab[i].chave;
            repeat (tab[i].hold) tick();
            chk($sformatf("tab%0d estavel", i), chave_estavel, tab[i].est);
            chk($sformatf("tab%0d digito", i), digito_bcd, tab[i].dig);
            chk($sformatf("tab%0d valido", i), valido, tab[i].val);
        end

        // Randomized stimulus against the model
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 3))
                0: Chave = 4'b0100;
                1: Chave = 4'b1100;
                2: Chave = 4'b1010;
                default: Chave = 4'($urandom);
            endcase
            repeat ($urandom_range(1, 14)) tick();
            if (k == 60) begin
                #2 reset_n = 1'b0;
                tick();
                reset_n = 1'b1;
            end
        end

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
